// File: rtl/exp3_varredura_controle.sv
// Sweep scheduler: steps the servo through four positions, waits for settling, fires one
// measurement per position and captures the BCD distance. VARREDURA_MINIMO_EN adds the min tracker.
module exp3_varredura_controle #(
    parameter int unsigned ESPERA_SERVO = 25_000_000,
    parameter int unsigned TIMEOUT      = 2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic [1:0]  posicao,
    output logic        medir,
    output logic [11:0] distancia,
    output logic [1:0]  pos_medida,
    output logic        nova_medida,
    output logic        erro,
    output logic        fim_varredura,
    output logic [11:0] dist_min,
    output logic [1:0]  pos_min,
    output logic [3:0]  db_estado
);

    localparam int unsigned EspW = (ESPERA_SERVO > 1) ? $clog2(ESPERA_SERVO) : 1;
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [EspW-1:0] EspFim = EspW'(ESPERA_SERVO - 1);
    localparam logic [TmoW-1:0] TmoFim = TmoW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StInicial   = 4'd0,
        StPrepara   = 4'd1,
        StPosiciona = 4'd2,
        StEspera    = 4'd3,
        StMede      = 4'd4,
        StAguarda   = 4'd5,
        StArmazena  = 4'd6,
        StProxima   = 4'd7,
        StFim       = 4'd8
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [1:0]      posicao_q, posicao_d;
    logic [EspW-1:0] cnt_espera_q, cnt_espera_d;
    logic [TmoW-1:0] cnt_tmo_q, cnt_tmo_d;
    logic [11:0]     distancia_q, distancia_d;
    logic [1:0]      pos_medida_q, pos_medida_d;
    logic            erro_q, erro_d;

    // Event strobes shared with the optional min tracker.
    logic inicia_varredura;
    logic captura;
    logic fecha_varredura;

    always_comb begin
        estado_d         = estado_q;
        posicao_d        = posicao_q;
        cnt_espera_d     = cnt_espera_q;
        cnt_tmo_d        = cnt_tmo_q;
        distancia_d      = distancia_q;
        pos_medida_d     = pos_medida_q;
        erro_d           = erro_q;
        inicia_varredura = 1'b0;
        captura          = 1'b0;
        fecha_varredura  = 1'b0;

        unique case (estado_q)
            StInicial: begin
                if (ligar) begin
                    estado_d         = StPrepara;
                    inicia_varredura = 1'b1;
                end
            end
            StPrepara: begin
                estado_d = StPosiciona;
            end
            StPosiciona: begin
                cnt_espera_d = '0;
                estado_d     = StEspera;
            end
            StEspera: begin
                if (cnt_espera_q == EspFim) begin
                    estado_d = StMede;
                end else begin
                    cnt_espera_d = cnt_espera_q + 1'b1;
                end
            end
            StMede: begin
                cnt_tmo_d = '0;
                estado_d  = StAguarda;
            end
            StAguarda: begin
                // A late pronto still wins over the timeout in the same cycle.
                if (pronto) begin
                    captura      = 1'b1;
                    distancia_d  = medida;
                    pos_medida_d = posicao_q;
                    estado_d     = StArmazena;
                end else if (cnt_tmo_q == TmoFim) begin
                    erro_d   = 1'b1;
                    estado_d = StProxima;
                end else begin
                    cnt_tmo_d = cnt_tmo_q + 1'b1;
                end
            end
            StArmazena: begin
                estado_d = StProxima;
            end
            StProxima: begin
                if (posicao_q == 2'd3) begin
                    fecha_varredura = 1'b1;
                    estado_d        = StFim;
                end else begin
                    posicao_d = posicao_q + 2'd1;
                    estado_d  = StPosiciona;
                end
            end
            StFim: begin
                if (ligar) begin
                    estado_d         = StPrepara;
                    inicia_varredura = 1'b1;
                end else begin
                    estado_d = StInicial;
                end
            end
            default: begin
                estado_d = StInicial;
            end
        endcase

        // Sweep-start clears are applied on entry so PREPARA already shows position 0.
        if (inicia_varredura) begin
            posicao_d = 2'd0;
            erro_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= StInicial;
            posicao_q    <= 2'd0;
            cnt_espera_q <= '0;
            cnt_tmo_q    <= '0;
            distancia_q  <= 12'h000;
            pos_medida_q <= 2'd0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            posicao_q    <= posicao_d;
            cnt_espera_q <= cnt_espera_d;
            cnt_tmo_q    <= cnt_tmo_d;
            distancia_q  <= distancia_d;
            pos_medida_q <= pos_medida_d;
            erro_q       <= erro_d;
        end
    end

`ifdef VARREDURA_MINIMO_EN
    logic [11:0] trk_min_q, trk_min_d;
    logic [1:0]  trk_pos_q, trk_pos_d;
    logic [11:0] dist_min_q, dist_min_d;
    logic [1:0]  pos_min_q, pos_min_d;

    always_comb begin
        trk_min_d  = trk_min_q;
        trk_pos_d  = trk_pos_q;
        dist_min_d = dist_min_q;
        pos_min_d  = pos_min_q;
        if (inicia_varredura) begin
            trk_min_d = 12'hFFF;
            trk_pos_d = 2'd0;
        end else if (captura && (medida < trk_min_q)) begin
            // Strict compare: on ties the earlier position is kept.
            trk_min_d = medida;
            trk_pos_d = posicao_q;
        end
        if (fecha_varredura) begin
            dist_min_d = trk_min_q;
            pos_min_d  = trk_pos_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trk_min_q  <= 12'hFFF;
            trk_pos_q  <= 2'd0;
            dist_min_q <= 12'hFFF;
            pos_min_q  <= 2'd0;
        end else begin
            trk_min_q  <= trk_min_d;
            trk_pos_q  <= trk_pos_d;
            dist_min_q <= dist_min_d;
            pos_min_q  <= pos_min_d;
        end
    end

    assign dist_min = dist_min_q;
    assign pos_min  = pos_min_q;
`else
    logic unused_strobes;
    assign unused_strobes = ^{inicia_varredura, captura, fecha_varredura};
    assign dist_min       = 12'hFFF;
    assign pos_min        = 2'd0;
`endif

    assign posicao       = posicao_q;
    assign distancia     = distancia_q;
    assign pos_medida    = pos_medida_q;
    assign erro          = erro_q;
    assign medir         = (estado_q == StMede);
    assign nova_medida   = (estado_q == StArmazena);
    assign fim_varredura = (estado_q == StFim);
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_exp3_varredura_controle.sv
// Self-checking bench for the sweep scheduler: a procedural sweep-timeline model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_exp3_varredura_controle;

    localparam int unsigned E = 4;
    localparam int unsigned T = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto;
    logic [11:0] medida;
    logic [1:0]  posicao;
    logic        medir;
    logic [11:0] distancia;
    logic [1:0]  pos_medida;
    logic        nova_medida;
    logic        erro;
    logic        fim_varredura;
    logic [11:0] dist_min;
    logic [1:0]  pos_min;
    logic [3:0]  db_estado;

    always #5 clock = ~clock;

    exp3_varredura_controle #(
        .ESPERA_SERVO(E),
        .TIMEOUT     (T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .pronto       (pronto),
        .medida       (medida),
        .posicao      (posicao),
        .medir        (medir),
        .distancia    (distancia),
        .pos_medida   (pos_medida),
        .nova_medida  (nova_medida),
        .erro         (erro),
        .fim_varredura(fim_varredura),
        .dist_min     (dist_min),
        .pos_min      (pos_min),
        .db_estado    (db_estado)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef VARREDURA_MINIMO_EN
    localparam logic [11:0] ExpMin    = 12'h042;
    localparam logic [11:0] ExpPosMin = 12'd1;
`else
    localparam logic [11:0] ExpMin    = 12'hFFF;
    localparam logic [11:0] ExpPosMin = 12'd0;
`endif

    // ---------------- reference model: sweep as a timeline ----------------
    logic [3:0]  m_state;
    logic [1:0]  m_pos, m_posmed, m_pmin;
    logic [11:0] m_dist, m_dmin;
    logic        m_medir, m_nova, m_fim, m_erro;
    bit          ab;
    logic        s_pronto, s_ligar;
    logic [11:0] s_medida;

    task automatic tick();
        @(posedge clock);
        ab       = (reset !== 1'b1);
        s_pronto = pronto;
        s_ligar  = ligar;
        s_medida = medida;
        m_medir  = 1'b0;
        m_nova   = 1'b0;
        m_fim    = 1'b0;
    endtask

    task automatic model_run();
        logic [11:0] trk;
        logic [1:0]  tpos;
        bit          got;
        forever begin
            m_state = 4'd0;
            do begin
                tick();
                if (ab) return;
            end while (!s_ligar);
            do begin
                m_state = 4'd1; m_pos = 2'd0; m_erro = 1'b0; trk = 12'hFFF; tpos = 2'd0;
                tick();
                if (ab) return;
                for (int p = 0; p < 4; p++) begin
                    m_state = 4'd2;
                    m_pos   = 2'(p);
                    tick();
                    if (ab) return;
                    m_state = 4'd3;
                    repeat (E) begin
                        tick();
                        if (ab) return;
                    end
                    m_state = 4'd4;
                    m_medir = 1'b1;
                    tick();
                    if (ab) return;
                    m_state = 4'd5;
                    got = 1'b0;
                    for (int t = 0; t < int'(T); t++) begin
                        tick();
                        if (ab) return;
                        if (s_pronto) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    if (got) begin
                        m_state = 4'd6; m_nova = 1'b1; m_dist = s_medida; m_posmed = 2'(p);
                        if (s_medida < trk) begin
                            trk  = s_medida;
                            tpos = 2'(p);
                        end
                        tick();
                        if (ab) return;
                        m_state = 4'd7;
                    end else begin
                        m_state = 4'd7;
                        m_erro  = 1'b1;
                    end
                    tick();
                    if (ab) return;
                end
                m_state = 4'd8;
                m_fim   = 1'b1;
`ifdef VARREDURA_MINIMO_EN
                m_dmin = trk;
                m_pmin = tpos;
`endif
                tick();
                if (ab) return;
            end while (s_ligar);
        end
    endtask

    initial begin
        forever begin
            m_state = 4'd0; m_pos = 2'd0; m_dist = 12'h000; m_posmed = 2'd0; m_erro = 1'b0;
            m_dmin = 12'hFFF; m_pmin = 2'd0; m_medir = 1'b0; m_nova = 1'b0; m_fim = 1'b0;
            wait (reset === 1'b1);
            model_run();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            chk("rst_estado", 12'(db_estado), 12'd0);
            chk("rst_posicao", 12'(posicao), 12'd0);
            chk("rst_medir", 12'(medir), 12'd0);
            chk("rst_distancia", distancia, 12'h000);
            chk("rst_pos_medida", 12'(pos_medida), 12'd0);
            chk("rst_nova", 12'(nova_medida), 12'd0);
            chk("rst_erro", 12'(erro), 12'd0);
            chk("rst_fim", 12'(fim_varredura), 12'd0);
            chk("rst_dist_min", dist_min, 12'hFFF);
            chk("rst_pos_min", 12'(pos_min), 12'd0);
        end else begin
            chk("db_estado", 12'(db_estado), 12'(m_state));
            chk("posicao", 12'(posicao), 12'(m_pos));
            chk("medir", 12'(medir), 12'(m_medir));
            chk("distancia", distancia, m_dist);
            chk("pos_medida", 12'(pos_medida), 12'(m_posmed));
            chk("nova_medida", 12'(nova_medida), 12'(m_nova));
            chk("erro", 12'(erro), 12'(m_erro));
            chk("fim_varredura", 12'(fim_varredura), 12'(m_fim));
            chk("dist_min", dist_min, m_dmin);
            chk("pos_min", 12'(pos_min), 12'(m_pmin));
        end
    end

    int nova_cnt = 0;
    always @(posedge clock) if (nova_medida === 1'b1) nova_cnt++;

    // ---------------- sensor responder ----------------
    int          fixed_k     = 3;
    int          timeout_pos = -1;
    bit          use_seq     = 1'b1;
    bit          spur_espera = 1'b0;
    bit          spur_rand   = 1'b0;
    logic [11:0] seq [4];

    function automatic logic [11:0] rand_bcd();
        logic [3:0] c, d, u;
        c = 4'($urandom_range(0, 9));
        d = 4'($urandom_range(0, 9));
        u = 4'($urandom_range(0, 9));
        return {c, d, u};
    endfunction

    initial begin
        int cd;
        cd     = 0;
        pronto = 1'b0;
        medida = 12'h000;
        forever begin
            @(negedge clock);
            pronto = 1'b0;
            medida = rand_bcd();
            if (medir === 1'b1) begin
                cd = (fixed_k > 0) ? fixed_k : int'($urandom_range(1, 10));
                if (timeout_pos == int'(posicao)) cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    pronto = 1'b1;
                    medida = use_seq ? seq[posicao] : rand_bcd();
                end
            end else if ((spur_espera && db_estado == 4'd3) ||
                         (spur_rand && $urandom_range(0, 15) == 0)) begin
                pronto = 1'b1;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_fim(input string name);
        int n;
        n = 0;
        while (fim_varredura !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, 12'(fim_varredura), 12'd1);
    endtask

    task automatic wait_pos_state(input logic [1:0] p, input logic [3:0] s, input string name);
        int n;
        n = 0;
        while (!(posicao === p && db_estado === s) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, {6'd0, posicao, db_estado}, {6'd0, p, s});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, aw;
        seq[0] = 12'h150; seq[1] = 12'h042; seq[2] = 12'h300; seq[3] = 12'h042;
        reset = 1'b1;
        ligar = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("held_reset_estado", 12'(db_estado), 12'd0);
        #1 reset = 1'b1;

        // First sweep: settle latency and min tracking with a tie.
        wait_pos_state(2'd0, 4'd2, "first_posiciona");
        lat = 0;
        while (medir !== 1'b1 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        chk("medir_latency", 12'(lat), 12'd5);
        wait_fim("fim_sweep1");
        chk("sweep1_novas", 12'(nova_cnt), 12'd4);
        chk("sweep1_dist_min", dist_min, ExpMin);
        chk("sweep1_pos_min", 12'(pos_min), ExpPosMin);
        chk("model_dist_min", m_dmin, ExpMin);
        chk("sweep1_distancia", distancia, 12'h042);
        chk("sweep1_pos_medida", 12'(pos_medida), 12'd3);
        @(negedge clock);
        chk("restart_prepara", 12'(db_estado), 12'd1);
        chk("restart_posicao", 12'(posicao), 12'd0);

        // Second sweep: timeout at position 2.
        nova_cnt    = 0;
        timeout_pos = 2;
        wait_pos_state(2'd2, 4'd5, "aguarda_pos2");
        aw = 0;
        while (db_estado === 4'd5 && aw < 20) begin
            @(negedge clock);
            aw++;
        end
        chk("aguarda_len", 12'(aw), 12'd8);
        chk("timeout_erro", 12'(erro), 12'd1);
        chk("timeout_proxima", 12'(db_estado), 12'd7);
        @(negedge clock);
        chk("timeout_advance", 12'(posicao), 12'd3);
        wait_fim("fim_sweep2");
        timeout_pos = -1;
        chk("sweep2_novas", 12'(nova_cnt), 12'd3);
        chk("sweep2_erro_fim", 12'(erro), 12'd1);
        @(negedge clock);
        chk("erro_cleared", 12'(erro), 12'd0);

        // Third sweep: ligar dropped at position 1.
        nova_cnt = 0;
        wait_pos_state(2'd1, 4'd2, "pos1_reached");
        ligar = 1'b0;
        wait_fim("fim_sweep3");
        chk("sweep3_novas", 12'(nova_cnt), 12'd4);
        @(negedge clock);
        chk("stop_inicial", 12'(db_estado), 12'd0);
        repeat (3) @(negedge clock);
        chk("stay_inicial", 12'(db_estado), 12'd0);
        chk("stay_posicao", 12'(posicao), 12'd3);

        // Fourth sweep: spurious pronto in ESPERA, pronto on the timeout cycle.
        nova_cnt    = 0;
        fixed_k     = 8;
        spur_espera = 1'b1;
        ligar       = 1'b1;
        wait_fim("fim_sweep4");
        spur_espera = 1'b0;
        chk("sweep4_novas", 12'(nova_cnt), 12'd4);
        chk("sweep4_erro", 12'(erro), 12'd0);
        chk("sweep4_distancia", distancia, 12'h042);
        chk("sweep4_dist_min", dist_min, ExpMin);

        // Async reset while waiting for pronto.
        wait_pos_state(2'd2, 4'd5, "aguarda_before_reset");
        #1 reset = 1'b0;
        #1;
        chk("async_estado", 12'(db_estado), 12'd0);
        chk("async_posicao", 12'(posicao), 12'd0);
        chk("async_medir", 12'(medir), 12'd0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        // Randomized traffic.
        use_seq   = 1'b0;
        fixed_k   = 0;
        spur_rand = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if ($urandom_range(0, 59) == 0) ligar = ~ligar;
            if ($urandom_range(0, 799) == 0) begin
                #1 reset = 1'b0;
                repeat (2) @(negedge clock);
                #1 reset = 1'b1;
            end
        end
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp3_varredura_controle.md
# exp3_varredura_controle

Sweep scheduler for the ultrasonic rangefinder with servo-mounted sensor. It steps the servo through the four PWM positions and waits a fixed settle time at each one. It then fires one measurement request into the sensor block and captures the 3-digit BCD distance returned. It sits above the sensor and PWM instances: it drives their `medir` and `largura` inputs and consumes `pronto` and the BCD measurement.

## Interface
- `ESPERA_SERVO`, default 25_000_000: settle cycles after each position change (0.5 s at 50 MHz); must be ≥ 1.
- `TIMEOUT`, default 2_500_000: max cycles waiting for `pronto` after `medir` (50 ms at 50 MHz); must be ≥ 1.
- `clock` in, 1: system clock, all logic on rising edge.
- `reset` in, 1: asynchronous, active-low reset (0 = reset asserted).
- `ligar` in, 1: level; 1 runs sweeps continuously, 0 stops at end of current sweep.
- `pronto` in, 1: measurement-done from sensor block.
- `medida` in, 12: BCD distance {hundreds, tens, units} from sensor block.
- `posicao` out, 2: servo position code to PWM block.
- `medir` out, 1: one-cycle measurement request to sensor block.
- `distancia` out, 12: last captured BCD distance.
- `pos_medida` out, 2: position at which `distancia` was captured.
- `nova_medida` out, 1: one-cycle pulse when `distancia`/`pos_medida` update.
- `erro` out, 1: sticky timeout flag, cleared at start of each sweep.
- `fim_varredura` out, 1: one-cycle pulse after position 3 is processed.
- `dist_min` out, 12: smallest valid distance of last completed sweep (see Configuration).
- `pos_min` out, 2: position of `dist_min`.
- `db_estado` out, 4: current state code.

## Operation
- States and codes: INICIAL 0, PREPARA 1, POSICIONA 2, ESPERA 3, MEDE 4, AGUARDA 5, ARMAZENA 6, PROXIMA 7, FIM 8.
- INICIAL: idle, `posicao` held. Goes to PREPARA when `ligar`=1.
- PREPARA: `posicao`←0, `erro`←0, min tracker ←12'hFFF/0. Goes to POSICIONA.
- POSICIONA: settle counter cleared. Goes to ESPERA.
- ESPERA: counts to ESPERA_SERVO−1, then goes to MEDE.
- MEDE: `medir`=1 for exactly this cycle, timeout counter cleared. Goes to AGUARDA.
- AGUARDA: if `pronto`=1, goes to ARMAZENA. Else if timeout counter reaches TIMEOUT−1, sets `erro`=1 and goes to PROXIMA with no capture.
- ARMAZENA: `distancia`←`medida`, `pos_medida`←`posicao`, `nova_medida`=1. Min update applies (strictly less-than; ties keep the earlier position). Goes to PROXIMA.
- PROXIMA: if `posicao`=3, goes to FIM. Else `posicao`←`posicao`+1 and goes to POSICIONA.
- FIM: `fim_varredura`=1, `dist_min`/`pos_min` outputs load from the tracker. Goes to PREPARA if `ligar`=1, else to INICIAL.
- BCD compare is done as an unsigned 12-bit compare; valid BCD preserves ordering. No conversion is performed.
- `pronto` asserted outside AGUARDA is ignored. `pronto` and a timeout in the same cycle: `pronto` wins.
- Dropping `ligar` mid-sweep has no effect until FIM.

## Timing
- Reset values: state INICIAL, `posicao`=0, `medir`=0, `distancia`=0, `pos_medida`=0, `nova_medida`=0, `erro`=0, `fim_varredura`=0, `dist_min`=12'hFFF, `pos_min`=0, `db_estado`=0.
- Reset is asynchronous. Asserting it mid-sweep returns to INICIAL immediately, with no pulse outputs in that cycle.
- All outputs are registered or decoded from the registered state (Moore); no input-to-output combinational path.
- Position-change to `medir` pulse: exactly ESPERA_SERVO+1 cycles (POSICIONA + ESPERA_SERVO cycles in ESPERA).
- `pronto` sampled high in cycle n: `nova_medida` and the updated `distancia` are visible in cycle n+1.
- Per-position duration when `pronto` arrives k cycles after `medir`: ESPERA_SERVO + k + 4 cycles.

## Configuration
- `VARREDURA_MINIMO_EN` defined: min tracker, `dist_min` and `pos_min` behave as above.
- Undefined: tracker logic is absent, `dist_min` is tied to 12'hFFF and `pos_min` to 0; all other behaviour is identical.

## Test plan
Parameters: ESPERA_SERVO=4, TIMEOUT=8 unless stated.
- Reset held low, `ligar`=1 → all outputs at reset values, `db_estado`=0. Release reset → `posicao`=0 and the first `medir` pulse arrives 5 cycles after entering POSICIONA.
- Full sweep: `pronto` 3 cycles after each `medir`, `medida`=12'h150, 12'h042, 12'h300, 12'h042 → four `nova_medida` pulses, then `fim_varredura`, `dist_min`=12'h042, `pos_min`=1 (tie keeps the first).
- Timeout at position 2: `pronto` withheld → `erro`=1 after 8 cycles in AGUARDA, no `nova_medida` for position 2, `posicao` advances to 3. `erro` clears in the next PREPARA.
- `ligar` dropped during position 1 → sweep completes through position 3, `fim_varredura` pulses, then state INICIAL. With `ligar` held high instead, the next cycle after FIM is PREPARA and `posicao` returns to 0.
- Spurious `pronto` during ESPERA and `pronto` coinciding with the timeout cycle → the first is ignored. The second is captured with `erro` unchanged.
- Async reset asserted in AGUARDA → state 0, `posicao`=0 and `medir`=0 before the next clock edge. Rebuild without `VARREDURA_MINIMO_EN` → `dist_min` stays 12'hFFF after a full sweep.
